// File: rtl/icache_refill_pkg.sv
// Shared types and default geometry for the icache refill write engine.
//   refill_state_t : refill FSM encoding
//   RATIO          : memory beats per bank word (default geometry)
//   BEATS          : memory beats per cache line (default geometry)
//   WORD_IDX_W     : bank word index width within a line
//   BEAT_IDX_W     : beat index width within a line
//   idx_w()        : index width for n items, never below 1
package icache_refill_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MREQ  = 3'd1,
    RECV  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } refill_state_t;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_MEM_WIDTH  = 32;
  localparam int DEF_LINE_WORDS = 4;

  localparam int RATIO      = DEF_DATA_WIDTH / DEF_MEM_WIDTH;
  localparam int BEATS      = DEF_LINE_WORDS * RATIO;
  localparam int WORD_IDX_W = $clog2(DEF_LINE_WORDS);
  localparam int BEAT_IDX_W = $clog2(BEATS);

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_refill_packer.sv
// Packs MEM_WIDTH memory beats into one DATA_WIDTH bank word, little-endian
// (beat k of a word lands at bits [k*MEM_WIDTH +: MEM_WIDTH]).
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   clear_i        drop any partial word and restart at slot 0
//   beat_valid_i   accept beat_data_i this cycle
//   beat_data_i    memory beat
//   word_valid_o   1-cycle pulse the cycle after a word's last beat
//   word_o         completed word, held until the next completion
module icache_refill_packer
  import icache_refill_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  beat_valid_i,
  input  logic [MEM_WIDTH-1:0]  beat_data_i,
  output logic                  word_valid_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  localparam int N_RATIO = DATA_WIDTH / MEM_WIDTH;
  localparam int W_SLOT  = idx_w(N_RATIO);

  logic [W_SLOT-1:0]     slot_q, slot_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  wv_q, wv_d;

  // The completed word is copied out of the accumulator so the first beat of
  // the next word can land in the same cycle the previous word is written.
  always_comb begin
    slot_d = slot_q;
    acc_d  = acc_q;
    word_d = word_q;
    wv_d   = 1'b0;
    if (clear_i) begin
      slot_d = '0;
      acc_d  = '0;
    end else if (beat_valid_i) begin
      acc_d[slot_q*MEM_WIDTH +: MEM_WIDTH] = beat_data_i;
      if (slot_q == W_SLOT'(N_RATIO - 1)) begin
        slot_d = '0;
        word_d = acc_d;
        wv_d   = 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
      acc_q  <= '0;
      word_q <= '0;
      wv_q   <= 1'b0;
    end else begin
      slot_q <= slot_d;
      acc_q  <= acc_d;
      word_q <= word_d;
      wv_q   <= wv_d;
    end
  end

  assign word_valid_o = wv_q;
  assign word_o       = word_q;

endmodule

// File: rtl/icache_refill_writer.sv
// Icache data-bank refill write engine. Takes a line refill command, issues
// one burst read, packs memory beats into bank words and writes them out.
// Optional build macro ICACHE_REFILL_BYPASS_EN adds a same-cycle beat
// forwarding port so fetch can restart before the line is complete.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   refill_req_i/gnt_o            refill command handshake (granted in IDLE only)
//   refill_addr_i, refill_set_i   line byte address, bank line index
//   mem_req_o/gnt_i, mem_addr_o   burst read request
//   mem_rvalid_i/rdata_i/rerr_i   read beats (no backpressure)
//   ram_req_o/write_o/waddr_o/wdata_o/be_o   bank write port
//   byp_valid_o/data_o/idx_o      beat forwarding (ICACHE_REFILL_BYPASS_EN)
//   refill_done_o, refill_err_o   line complete pulse, sticky bus error
//
// state | meaning
// IDLE  | waiting for a refill command; sticky error cleared
// MREQ  | burst request held on the memory port until granted
// RECV  | collecting beats; completed words written the following cycle
// FLUSH | write cycle of the final word
// DONE  | refill_done_o pulse, refill_err_o reports the line's error
module icache_refill_writer
  import icache_refill_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 7,
  parameter int MEM_WIDTH      = 32,
  parameter int LINE_WORDS     = 4,
  parameter int MEM_ADDR_WIDTH = 32
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      refill_req_i,
  output logic                                      refill_gnt_o,
  input  logic [MEM_ADDR_WIDTH-1:0]                 refill_addr_i,
  input  logic [ADDR_WIDTH-$clog2(LINE_WORDS)-1:0]  refill_set_i,
  output logic                                      mem_req_o,
  input  logic                                      mem_gnt_i,
  output logic [MEM_ADDR_WIDTH-1:0]                 mem_addr_o,
  input  logic                                      mem_rvalid_i,
  input  logic [MEM_WIDTH-1:0]                      mem_rdata_i,
  input  logic                                      mem_rerr_i,
  output logic                                      ram_req_o,
  output logic                                      ram_write_o,
  output logic [ADDR_WIDTH-1:0]                     ram_waddr_o,
  output logic [DATA_WIDTH-1:0]                     ram_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                   ram_be_o,
`ifdef ICACHE_REFILL_BYPASS_EN
  output logic                                      byp_valid_o,
  output logic [MEM_WIDTH-1:0]                      byp_data_o,
  output logic [$clog2(LINE_WORDS*(DATA_WIDTH/MEM_WIDTH))-1:0] byp_idx_o,
`endif
  output logic                                      refill_done_o,
  output logic                                      refill_err_o
);

  localparam int N_RATIO = DATA_WIDTH / MEM_WIDTH;
  localparam int N_BEATS = LINE_WORDS * N_RATIO;
  localparam int W_WIDX  = $clog2(LINE_WORDS);
  localparam int W_BIDX  = $clog2(N_BEATS);
  localparam int W_SET   = ADDR_WIDTH - W_WIDX;

  refill_state_t             state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [W_SET-1:0]          set_q, set_d;
  logic [W_BIDX-1:0]         beat_q, beat_d;
  logic [W_WIDX-1:0]         word_q, word_d;
  logic                      err_q, err_d;

  logic                      beat_in;
  logic                      pk_valid;
  logic [DATA_WIDTH-1:0]     pk_word;
  logic                      wr_en;

  assign beat_in = (state_q == RECV) && mem_rvalid_i;

  icache_refill_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WIDTH  (MEM_WIDTH)
  ) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (state_q == IDLE),
    .beat_valid_i (beat_in),
    .beat_data_i  (mem_rdata_i),
    .word_valid_o (pk_valid),
    .word_o       (pk_word)
  );

  // Once a beat has errored, the word containing it and every later word are
  // dropped; err_q is already set by the time such a word reaches the write
  // cycle because the write trails the word's last beat by one cycle.
  assign wr_en = pk_valid && !err_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    set_d   = set_q;
    beat_d  = beat_q;
    word_d  = word_q;
    err_d   = err_q;

    refill_gnt_o  = 1'b0;
    mem_req_o     = 1'b0;
    mem_addr_o    = '0;
    refill_done_o = 1'b0;
    refill_err_o  = 1'b0;

    if (pk_valid) begin
      word_d = word_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (refill_req_i) begin
          refill_gnt_o = 1'b1;
          addr_d       = refill_addr_i;
          set_d        = refill_set_i;
          beat_d       = '0;
          word_d       = '0;
          state_d      = MREQ;
        end
      end
      MREQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = addr_q;
        if (mem_gnt_i) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (mem_rvalid_i) begin
          beat_d = beat_q + 1'b1;
          if (mem_rerr_i) begin
            err_d = 1'b1;
          end
          if (beat_q == W_BIDX'(N_BEATS - 1)) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        state_d = DONE;
      end
      DONE: begin
        refill_done_o = 1'b1;
        refill_err_o  = err_q;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      set_q   <= '0;
      beat_q  <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      set_q   <= set_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  assign ram_req_o   = wr_en;
  assign ram_write_o = wr_en;
  assign ram_waddr_o = wr_en ? {set_q, word_q} : '0;
  assign ram_wdata_o = wr_en ? pk_word : '0;
  assign ram_be_o    = {(DATA_WIDTH/8){wr_en}};

`ifdef ICACHE_REFILL_BYPASS_EN
  assign byp_valid_o = beat_in && !mem_rerr_i;
  assign byp_data_o  = mem_rdata_i;
  assign byp_idx_o   = beat_q;
`endif

  // Read beats are only expected while a burst is being received.
  a_rvalid_in_recv : assert property (
    @(posedge clk) disable iff (!rst_n) mem_rvalid_i |-> (state_q == RECV)
  );

endmodule

// File: tb/tb_icache_refill_writer.sv
module tb_icache_refill_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        refill_req;
  logic        refill_gnt;
  logic [31:0] refill_addr;
  logic [4:0]  refill_set;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rerr;
  logic        ram_req;
  logic        ram_write;
  logic [6:0]  ram_waddr;
  logic [63:0] ram_wdata;
  logic [7:0]  ram_be;
  logic        refill_done;
  logic        refill_err;
`ifdef ICACHE_REFILL_BYPASS_EN
  logic        byp_valid;
  logic [31:0] byp_data;
  logic [2:0]  byp_idx;
`endif

  always #5 clk = ~clk;

  icache_refill_writer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .refill_req_i  (refill_req),
    .refill_gnt_o  (refill_gnt),
    .refill_addr_i (refill_addr),
    .refill_set_i  (refill_set),
    .mem_req_o     (mem_req),
    .mem_gnt_i     (mem_gnt),
    .mem_addr_o    (mem_addr),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .mem_rerr_i    (mem_rerr),
    .ram_req_o     (ram_req),
    .ram_write_o   (ram_write),
    .ram_waddr_o   (ram_waddr),
    .ram_wdata_o   (ram_wdata),
    .ram_be_o      (ram_be),
`ifdef ICACHE_REFILL_BYPASS_EN
    .byp_valid_o   (byp_valid),
    .byp_data_o    (byp_data),
    .byp_idx_o     (byp_idx),
`endif
    .refill_done_o (refill_done),
    .refill_err_o  (refill_err)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [4:0]  set;
    logic        mgnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rerr;
    int          bidx;
    logic        e_gnt;
    logic        e_mreq;
    logic [31:0] e_maddr;
    logic        e_wr;
    logic [6:0]  e_waddr;
    logic [63:0] e_wdata;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t vq[$];
  int   vecs = 0;
  int   miss = 0;

  logic [6:0]  wq_a[$];
  logic [63:0] wq_d[$];
  int          done_cnt = 0;
  bit          mon_en = 1'b0;

  always @(negedge clk) begin
    #2;
    if (mon_en && ram_req) begin
      wq_a.push_back(ram_waddr);
      wq_d.push_back(ram_wdata);
    end
    if (mon_en && refill_done) done_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One refill as seen cycle by cycle: command, MREQ wait, 8 back-to-back
  // beats, FLUSH, DONE. err_beat < 0 means no bus error.
  task automatic push_line(input logic [31:0] a, input logic [4:0] s, input int ngnt,
                           input int err_beat, input logic hold, input logic [31:0] base);
    vec_t v;
    v = '{default: '0};
    v.req = 1'b1; v.addr = a; v.set = s; v.e_gnt = 1'b1;
    vq.push_back(v);
    for (int i = 0; i <= ngnt; i++) begin
      v = '{default: '0};
      v.req = hold; v.mgnt = (i == ngnt); v.e_mreq = 1'b1; v.e_maddr = a;
      vq.push_back(v);
    end
    for (int i = 0; i < 9; i++) begin
      v = '{default: '0};
      v.req = hold;
      if (i < 8) begin
        v.rvalid = 1'b1; v.rdata = base + 32'(i); v.rerr = (i == err_beat); v.bidx = i;
      end
      // word w completes on beat 2w+1 and is written on the following row
      if (i >= 2 && (i % 2) == 0) begin
        int w;
        w = i / 2 - 1;
        if (err_beat < 0 || err_beat > 2 * w + 1) begin
          v.e_wr = 1'b1;
          v.e_waddr = {s, 2'(w)};
          v.e_wdata = {base + 32'(2 * w + 1), base + 32'(2 * w)};
        end
      end
      vq.push_back(v);
    end
    v = '{default: '0};
    v.req = hold; v.e_done = 1'b1; v.e_err = (err_beat >= 0);
    vq.push_back(v);
  endtask

  task automatic run_gap_line(input logic [31:0] a, input logic [4:0] s, input logic [31:0] base);
    wq_a.delete(); wq_d.delete(); done_cnt = 0; mon_en = 1'b1;
    @(negedge clk);
    refill_req = 1'b1; refill_addr = a; refill_set = s;
    #1 chk("gap_gnt", 64'(refill_gnt), 64'd1);
    @(negedge clk);
    refill_req = 1'b0; mem_gnt = 1'b1;
    #1 chk("gap_mem_addr", {31'd0, mem_req, mem_addr}, {31'd1, a});
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      mem_rvalid = 1'b0;
      repeat (gap) @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = base + 32'(i);
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    chk("gap_write_count", 64'(wq_a.size()), 64'd4);
    for (int w = 0; w < 4 && w < wq_a.size(); w++) begin
      chk("gap_waddr", 64'(wq_a[w]), 64'({s, 2'(w)}));
      chk("gap_wdata", wq_d[w], {base + 32'(2 * w + 1), base + 32'(2 * w)});
    end
    chk("gap_done_pulses", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    logic ok;
    rst_n = 1'b0; refill_req = 1'b0; refill_addr = '0; refill_set = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rerr = 1'b0;

    // tests 1, 3 (error then clean), 5 (req held, back-to-back set 3 then 0)
    push_line(32'h0000_1000, 5'd3, 2, -1, 1'b0, 32'h0);
    push_line(32'h0000_2000, 5'd3, 0,  5, 1'b0, 32'h10);
    push_line(32'h0000_1000, 5'd3, 1, -1, 1'b0, 32'h20);
    push_line(32'h0000_3000, 5'd3, 0, -1, 1'b1, 32'h30);
    push_line(32'h0000_3040, 5'd0, 1, -1, 1'b0, 32'h40);
    begin
      vec_t v;
      v = '{default: '0};
      vq.push_back(v);
    end

    repeat (3) @(negedge clk);
    #1 chk("reset_outputs",
           {refill_gnt, mem_req, mem_addr, ram_req, ram_write, ram_waddr, ram_be, refill_done, refill_err},
           64'd0);
    chk("reset_wdata", ram_wdata, 64'd0);
    rst_n = 1'b1;

    foreach (vq[k]) begin
      @(negedge clk);
      refill_req = vq[k].req; refill_addr = vq[k].addr; refill_set = vq[k].set;
      mem_gnt = vq[k].mgnt; mem_rvalid = vq[k].rvalid; mem_rdata = vq[k].rdata; mem_rerr = vq[k].rerr;
      #1;
      ok = (refill_gnt === vq[k].e_gnt) && (mem_req === vq[k].e_mreq) &&
           (!vq[k].e_mreq || mem_addr === vq[k].e_maddr) &&
           (ram_req === vq[k].e_wr) && (ram_write === vq[k].e_wr) &&
           (ram_be === (vq[k].e_wr ? 8'hFF : 8'h00)) &&
           (!vq[k].e_wr || (ram_waddr === vq[k].e_waddr && ram_wdata === vq[k].e_wdata)) &&
           (refill_done === vq[k].e_done) && (!vq[k].e_done || refill_err === vq[k].e_err);
`ifdef ICACHE_REFILL_BYPASS_EN
      ok = ok && (byp_valid === (vq[k].rvalid && !vq[k].rerr)) &&
           (!(vq[k].rvalid && !vq[k].rerr) || (byp_data === vq[k].rdata && byp_idx === 3'(vq[k].bidx)));
`endif
      vecs++;
      if (!ok) begin
        miss++;
        $display("FAIL row %0d: got gnt=%b mreq=%b maddr=%h wr=%b/%b be=%h waddr=%0d wdata=%h done=%b err=%b expected gnt=%b mreq=%b maddr=%h wr=%b waddr=%0d wdata=%h done=%b err=%b",
                 k, refill_gnt, mem_req, mem_addr, ram_req, ram_write, ram_be, ram_waddr, ram_wdata,
                 refill_done, refill_err, vq[k].e_gnt, vq[k].e_mreq, vq[k].e_maddr, vq[k].e_wr,
                 vq[k].e_waddr, vq[k].e_wdata, vq[k].e_done, vq[k].e_err);
      end
    end

    // test 2: random beat gaps
    run_gap_line(32'h0000_1000, 5'd3, 32'h0);
    run_gap_line(32'h0000_5000, 5'd9, 32'h50);

    // test 4: reset during beat 4, then a clean refill
    wq_a.delete(); wq_d.delete(); done_cnt = 0; mon_en = 1'b1;
    @(negedge clk);
    refill_req = 1'b1; refill_addr = 32'h0000_4000; refill_set = 5'd7;
    @(negedge clk);
    refill_req = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'(i);
      @(negedge clk);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'd4; rst_n = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1 chk("midreset_outputs",
           {refill_gnt, mem_req, mem_addr, ram_req, ram_write, ram_waddr, ram_be, refill_done, refill_err},
           64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    chk("midreset_no_done", 64'(done_cnt), 64'd0);
    run_gap_line(32'h0000_4000, 5'd7, 32'h60);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
